// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch front end: machine word width,
// default reset PC, canonical NOP encoding, fetch FSM state encoding, the
// {pc, instr} prefetch entry layout and a word-alignment helper.
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// Synchronous prefetch FIFO holding {pc, instr} entries between the memory
// interface and decode. Flush wins over push and pop in the same cycle.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (control state only)
//   push       write push_data at the tail (ignored when full, unless popping)
//   push_data  entry to write
//   pop        remove the head (ignored when empty)
//   flush      discard all entries
//   head       entry at the head; all zeros when empty
//   count      number of valid entries
//   empty      count == 0
//   full       count == DEPTH
// -----------------------------------------------------------------------------
module instr_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    // Zero the head when empty so decode never sees stale words.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Core front end. Owns the fetch PC, issues one word read at a time to
// instruction memory over req/ack, buffers returned words in a prefetch FIFO
// and hands {instr, pc} pairs to decode over valid/ready. A redirect from
// execute flushes the FIFO, retargets the PC and drains any read in flight.
//
// Optional feature (macro IFETCH_MISALIGN_EN): adds output 'misalign'. A
// redirect with a non-zero byte offset sets it sticky and halts fetching until
// reset. Without the macro the byte offset is silently cleared.
//
// Parameters:
//   RESET_PC     fetch PC loaded at reset
//   FIFO_DEPTH   prefetch entries (power of two, >= 2)
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   imem_req     read request, held until imem_ack
//   imem_addr    word address of the request
//   imem_ack     one-cycle acknowledge, imem_rdata valid with it
//   imem_rdata   returned instruction word
//   redirect     one-cycle taken branch/jump pulse
//   redirect_pc  new fetch target
//   instr        instruction at the FIFO head
//   instr_pc     PC of instr
//   instr_valid  FIFO not empty
//   instr_ready  decode accepts the head this cycle
//   misalign     (IFETCH_MISALIGN_EN only) sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready
`ifdef IFETCH_MISALIGN_EN
    ,
    output logic            misalign
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("instr_fetch: FIFO_DEPTH must be a power of two and at least 2");
    end

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             req_q, req_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             room_after_ack;
    logic             fetch_halt;

    // Only a WAIT-state ack carries live data; a redirect in the same cycle
    // kills it. Pops in a redirect cycle are dropped along with the flush.
    assign fifo_push  = (state_q == ST_WAIT) && imem_ack && !redirect;
    assign fifo_pop   = !fifo_empty && instr_ready && !redirect;
    assign push_entry = '{pc: addr_q, instr: imem_rdata};

    // After this cycle's push (and possible pop), is a slot still free for a
    // back-to-back request?
    assign room_after_ack = fifo_pop || (fifo_count < CNT_W'(FIFO_DEPTH - 1));

    instr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef IFETCH_MISALIGN_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q | (redirect && (redirect_pc[1:0] != 2'b00));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign   = misalign_q;
    assign fetch_halt = misalign_q;
`else
    assign fetch_halt = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;

        unique case (state_q)
            ST_IDLE: begin
                if (!redirect && !fetch_halt && !fifo_full) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // Read still in flight: keep the old address up and
                        // throw its data away when it lands.
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    if (room_after_ack) begin
                        addr_d = fetch_pc_q + XLEN'(4);
                    end else begin
                        req_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (redirect) begin
            fetch_pc_d = word_align(redirect_pc);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = !fifo_empty;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A memory responder answers requests
// with a fixed function of the address; a reference model tracks the expected
// sequential PC stream since the last redirect and queues {pc, instr} for each
// word that must reach decode. A separate monitor pops and compares on every
// decode handshake. Build with +define+IFETCH_MISALIGN_EN to cover the
// misaligned-redirect halt feature.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
`ifdef IFETCH_MISALIGN_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef IFETCH_MISALIGN_EN
        ,
        .misalign    (misalign)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_pc;
    bit          stale;
    int          wait_left;
    int          ack_delay_fixed;
    int          max_wait;
    bit          stray_en;
    int          ack_cnt;
    int          pop_cnt;
    logic [31:0] last_pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0020_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc  = 32'h0;
        stale     = 1'b0;
        wait_left = -1;
        ack_cnt   = 0;
        pop_cnt   = 0;
    endtask

    // One clock: act as memory, apply decode/redirect stimulus, advance model.
    task automatic drive_cycle(input bit rd, input logic [31:0] rd_pc, input bit rdy);
        @(posedge clk);
        #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        if (imem_req) begin
            if (wait_left < 0)
                wait_left = (ack_delay_fixed >= 0) ? ack_delay_fixed : int'($urandom_range(0, max_wait));
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_left  = -1;
                ack_cnt++;
            end else begin
                wait_left--;
            end
        end else begin
            wait_left = -1;
            if (stray_en && ($urandom_range(0, 9) == 0)) begin
                imem_ack   = 1'b1;
                imem_rdata = INSTR_NOP;
            end
        end
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rd_pc;

        if (rd) begin
            exp_q.delete();
            model_pc = rd_pc & ~32'h3;
            if (imem_req) stale = !imem_ack;
        end else if (imem_req && imem_ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                check32("fetch_addr", imem_addr, model_pc);
                exp_q.push_back('{pc: model_pc, word: mem_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic wait_req(input int budget, input bit rdy, input string name);
        for (int i = 0; i < budget; i++) begin
            drive_cycle(1'b0, 32'h0, rdy);
            if (imem_req) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: imem_req=0 after %0d cycles, expected 1", name, budget);
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (pop_cnt >= target) return;
            drive_cycle(1'b0, 32'h0, 1'b1);
        end
        @(negedge clk);
        if (pop_cnt < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: %0d instructions delivered, expected %0d", name, pop_cnt, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b0;
        imem_ack    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every decode handshake must match the head of the expected stream.
    always @(negedge clk) begin
        if (reset && instr_valid && !redirect) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_instr: got valid pc 0x%08h, expected no instruction", instr_pc);
            end else if (instr_ready) begin
                mon_e = exp_q.pop_front();
                check32("instr_pc", instr_pc, mon_e.pc);
                check32("instr", instr, mon_e.word);
                pop_cnt++;
                last_pop_pc = instr_pc;
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          req_seen;
        bit          rd;
        logic [31:0] tgt;

        ack_delay_fixed = 0;
        max_wait        = 3;
        stray_en        = 1'b0;
        last_pop_pc     = '0;
        model_reset();

        // Reset state
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_imem_req", {31'h0, imem_req}, 32'h0);
        check32("rst_imem_addr", imem_addr, 32'h0);
        check32("rst_instr", instr, 32'h0);
        check32("rst_instr_pc", instr_pc, 32'h0);
        check32("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
`ifdef IFETCH_MISALIGN_EN
        check32("rst_misalign", {31'h0, misalign}, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Streaming with a 0-wait memory
        wait_req(10, 1'b1, "first_req");
        check32("first_addr", imem_addr, 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            if (instr_valid) break;
        end
        check32("stream_pc0", instr_pc, 32'h0);
        check32("stream_instr0", instr, 32'h0010_0093);
        drive_cycle(1'b0, 32'h0, 1'b1);
        check32("stream_pc1", instr_pc, 32'h4);
        check32("stream_instr1", instr, 32'h0020_0113);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            check32("no_bubble", {31'h0, instr_valid}, 32'h1);
        end

        // Backpressure: only FIFO_DEPTH words accepted, then fetch stalls
        do_reset();
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 32'h0, 1'b0);
        check32("bp_ack_count", ack_cnt, 32'd2);
        check32("bp_req_low", {31'h0, imem_req}, 32'h0);
        check32("bp_valid", {31'h0, instr_valid}, 32'h1);
        drive_cycle(1'b0, 32'h0, 1'b1);
        wait_req(10, 1'b0, "bp_resume_req");
        check32("bp_first_pop", last_pop_pc, 32'h0);
        check32("bp_resume_addr", imem_addr, 32'h8);
        wait_pops(3, 20, "bp_drain");

        // Redirect while a slow read is outstanding
        do_reset();
        ack_delay_fixed = 3;
        wait_req(10, 1'b1, "inflight_req");
        drive_cycle(1'b1, 32'h100, 1'b1);
        ack_delay_fixed = 0;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            if (imem_req && imem_addr != 32'h0) begin
                req_seen = 1;
                break;
            end
        end
        check32("inflight_new_addr", imem_addr, 32'h100);
        check32("inflight_seen", req_seen, 32'd1);
        wait_pops(1, 20, "inflight_deliver");
        check32("inflight_first_pc", last_pop_pc, 32'h100);

        // Redirect coinciding with an ack and a pop attempt
        do_reset();
        ack_delay_fixed = 0;
        wait_req(10, 1'b0, "samecyc_req");
        drive_cycle(1'b1, 32'h200, 1'b1);
        check32("samecyc_pop_valid", {31'h0, instr_valid}, 32'h1);
        check32("samecyc_ack", {31'h0, imem_ack}, 32'h1);
        drive_cycle(1'b0, 32'h0, 1'b1);
        check32("samecyc_flushed", {31'h0, instr_valid}, 32'h0);
        check32("samecyc_req_drop", {31'h0, imem_req}, 32'h0);
        wait_req(10, 1'b1, "samecyc_new_req");
        check32("samecyc_new_addr", imem_addr, 32'h200);
        check32("samecyc_none_delivered", pop_cnt, 32'd0);
        wait_pops(1, 20, "samecyc_deliver");
        check32("samecyc_first_pc", last_pop_pc, 32'h200);

        // PC wrap across the top of the address space
        drive_cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        wait_pops(pop_cnt + 4, 40, "wrap_deliver");
        check32("wrap_pc", last_pop_pc, 32'h4);

        // Randomized traffic: waits, backpressure, redirects, stray acks
        ack_delay_fixed = -1;
        stray_en        = 1'b1;
        pop_cnt         = 0;
        for (int i = 0; i < 3000; i++) begin
            rd  = ($urandom_range(0, 99) < 3);
            tgt = {20'h0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
`ifndef IFETCH_MISALIGN_EN
            tgt[1:0] = 2'($urandom_range(0, 3));
`endif
            drive_cycle(rd, tgt, ($urandom_range(0, 99) < 70));
        end
        stray_en        = 1'b0;
        ack_delay_fixed = 0;
        n_checks++;
        if (pop_cnt < 300) begin
            n_fail++;
            $display("FAIL random_throughput: %0d instructions delivered, expected at least 300", pop_cnt);
        end

        // Misaligned redirect
        drive_cycle(1'b1, 32'h102, 1'b1);
`ifdef IFETCH_MISALIGN_EN
        req_seen = 0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b1);
            if (i >= 5 && imem_req) req_seen++;
        end
        check32("misalign_flag", {31'h0, misalign}, 32'h1);
        check32("misalign_halt_req", req_seen, 32'd0);
        check32("misalign_no_valid", {31'h0, instr_valid}, 32'h0);
`else
        wait_pops(pop_cnt + 1, 30, "misalign_deliver");
        check32("misalign_forced_pc", last_pop_pc, 32'h100);
`endif

        // Async reset in the middle of a request, stray ack around release
        ack_delay_fixed = 3;
        wait_req(20, 1'b1, "midreq_req");
        #3;
        reset = 1'b0;
        #1;
        check32("midreq_req_drop", {31'h0, imem_req}, 32'h0);
        check32("midreq_valid_drop", {31'h0, instr_valid}, 32'h0);
`ifdef IFETCH_MISALIGN_EN
        check32("midreq_misalign_clr", {31'h0, misalign}, 32'h0);
`endif
        model_reset();
        ack_delay_fixed = 0;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = INSTR_NOP;
        @(negedge clk);
        reset = 1'b1;
        wait_req(10, 1'b1, "midreq_restart");
        check32("midreq_restart_addr", imem_addr, 32'h0);
        wait_pops(2, 20, "midreq_deliver");
        check32("midreq_pc", last_pop_pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front end of the core. Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and hands {instr, pc} pairs to instr_decode with a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage and flushes all stale work.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.
- FIFO_DEPTH, 2, prefetch buffer entries. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  memory read request; held high until imem_ack
- imem_addr  out  32  word address of the request; low 2 bits always 0
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle
- imem_rdata  in  32  returned instruction word
- redirect  in  1  one-cycle pulse; branch or jump taken
- redirect_pc  in  32  new fetch target
- instr  out  32  instruction at the FIFO head
- instr_pc  out  32  PC of instr
- instr_valid  out  1  FIFO not empty
- instr_ready  in  1  decode accepts the head this cycle

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_PC; FIFO empty; state IDLE.
  - imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0.
- States: IDLE, WAIT, DRAIN.
- IDLE:
  - If no redirect and (fifo_count < FIFO_DEPTH), assert imem_req with imem_addr=fetch_pc on the next cycle and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - imem_req stays high and imem_addr stays stable until imem_ack.
  - On ack: push {imem_rdata, imem_addr} into the FIFO and set fetch_pc+=4 (32-bit wrap, 0xFFFF_FFFC -> 0).
  - Then, if the FIFO still has room, issue the next request back-to-back (imem_req stays high, imem_addr updates next cycle) and remain in WAIT; else drop imem_req and go to IDLE.
  - Only one request outstanding at a time. A request is only issued when a FIFO slot is free, so the FIFO can never overflow.
- Pop: when instr_valid && instr_ready, the head is removed at the clock edge. The next entry, if any, appears the following cycle.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Redirect has the highest priority:
  - FIFO is flushed in the same cycle; instr_valid=0 from the next cycle; any pop that cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - If a request is outstanding without an ack that cycle, go to DRAIN. Keep imem_req and the old address high until the ack, discard that data, then request the new PC.
  - If the ack arrives in the redirect cycle itself, discard the data and go directly to IDLE.
  - A redirect while in DRAIN updates fetch_pc only; the state stays DRAIN.
- imem_ack outside WAIT/DRAIN is ignored.
- Latency: from redirect to the first new instr_valid is at least 3 cycles with a 0-wait memory (ack the cycle after req).
- Reset mid-request: imem_req drops immediately (async); a later stray ack is ignored.

Optional Feature:
- Macro: IFETCH_MISALIGN_EN.
- Enabled:
  - Adds output misalign (1 bit), reset 0.
  - A redirect with redirect_pc[1:0]!=0 sets misalign sticky and flushes the FIFO.
  - Fetch then halts: any outstanding request is drained and no new requests are issued until reset.
- Disabled:
  - Port is absent; the low 2 bits are silently forced to 0.

Decomposition:
- Shared package: RESET_PC default, state encodings (IDLE/WAIT/DRAIN), XLEN=32, INSTR_NOP=32'h0000_0013.
- Sub-module instr_fifo: synchronous FIFO of {pc, instr}, parameter DEPTH, with push, pop, flush, count, empty and full.
  - Flush has priority over push.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> all outputs 0; after release, first imem_addr=0x0000_0000.
- Streaming: 0-wait memory returning 0x00100093, 0x00200113 with instr_ready=1 -> instr_pc sequence 0x0, 0x4 with matching instr; no bubbles after the first valid.
- Backpressure: instr_ready=0 -> exactly FIFO_DEPTH=2 acks accepted, then imem_req=0; raising instr_ready pops pc 0x0 and a new request is issued for 0x8.
- Redirect in flight: ack delayed 3 cycles, redirect to 0x100 during WAIT -> old data discarded, next imem_addr=0x100, first valid instr_pc=0x100.
- Redirect with ack in the same cycle, plus pop attempted -> neither word is delivered; next request is to redirect_pc.
- Misaligned redirect to 0x102: with IFETCH_MISALIGN_EN -> misalign=1 and no further imem_req; without it -> imem_addr=0x100.
